// File: rtl/pacman_motion_if.sv
// Bundle between the Pac-Man motion controller, its input sources, the wall-collision
// checker and the sprite renderer.
interface pacman_motion_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       stop_motion;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [9:0] probe_x_motion;
  logic [9:0] probe_y_motion;
  logic [2:0] cur_dir;
  logic       moving;
  logic       frame_done;

  // master: the environment (keyboard, vsync, collision checker, renderer)
  modport master (
    output frame_clk, keycode, stop_motion,
    input  pos_x, pos_y, probe_x_motion, probe_y_motion, cur_dir, moving, frame_done
  );

  // slave: the motion controller itself
  modport slave (
    input  frame_clk, keycode, stop_motion,
    output pos_x, pos_y, probe_x_motion, probe_y_motion, cur_dir, moving, frame_done
  );
endinterface

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man motion controller: buffers the WASD request and steps the sprite
// one pixel per clear probe of the external collision checker.
module pacman_motion #(
  parameter int START_X         = 16,
  parameter int START_Y         = 16,
  parameter int STEPS_PER_FRAME = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  pacman_motion_if.slave   bus,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PROBE_REQ = 2'd1,
    S_PROBE_CUR = 2'd2,
    S_STEP      = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    D_NONE  = 3'd0,
    D_UP    = 3'd1,
    D_DOWN  = 3'd2,
    D_LEFT  = 3'd3,
    D_RIGHT = 3'd4
  } dir_t;

  localparam logic [9:0] START_X_V = 10'(START_X);
  localparam logic [9:0] START_Y_V = 10'(START_Y);
  localparam logic [3:0] STEPS_V   = 4'(STEPS_PER_FRAME);

  function automatic dir_t key_to_dir(input logic [7:0] key);
    case (key)
      8'h1A:   key_to_dir = D_UP;
      8'h16:   key_to_dir = D_DOWN;
      8'h04:   key_to_dir = D_LEFT;
      8'h07:   key_to_dir = D_RIGHT;
      default: key_to_dir = D_NONE;
    endcase
  endfunction

  // Returns {x_motion, y_motion}; the unused axis is always zero.
  function automatic logic [19:0] dir_to_motion(input dir_t d);
    case (d)
      D_UP:    dir_to_motion = {10'h000, 10'h3FF};
      D_DOWN:  dir_to_motion = {10'h000, 10'h001};
      D_LEFT:  dir_to_motion = {10'h3FF, 10'h000};
      D_RIGHT: dir_to_motion = {10'h001, 10'h000};
      default: dir_to_motion = 20'h00000;
    endcase
  endfunction

  state_t     r_state;
  dir_t       r_req_dir;
  dir_t       r_cur_dir;
  logic [9:0] r_pos_x;
  logic [9:0] r_pos_y;
  logic       r_moving;
  logic       r_frame_done;
  logic [3:0] r_step_cnt;
  logic       r_frame_clk_d;

  state_t     w_state_next;
  dir_t       w_cur_next;
  dir_t       w_key_dir;
  dir_t       w_probe_dir;
  logic [9:0] w_pos_x_next;
  logic [9:0] w_pos_y_next;
  logic       w_moving_next;
  logic       w_done_next;
  logic [3:0] w_step_next;
  logic       w_frame_edge;
  logic [19:0] w_motion;

  assign w_key_dir    = key_to_dir(bus.keycode);
  assign w_frame_edge = bus.frame_clk & ~r_frame_clk_d;

  always_comb begin
    w_state_next  = r_state;
    w_cur_next    = r_cur_dir;
    w_pos_x_next  = r_pos_x;
    w_pos_y_next  = r_pos_y;
    w_moving_next = r_moving;
    w_done_next   = 1'b0;
    w_step_next   = r_step_cnt;
    w_probe_dir   = D_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_frame_edge) begin
          w_step_next  = 4'd0;
          w_state_next = S_PROBE_REQ;
        end
      end
      S_PROBE_REQ: begin
        // The registered request is probed, so a key change this cycle waits a pass.
        w_probe_dir = r_req_dir;
        if (r_req_dir != D_NONE && !bus.stop_motion) begin
          w_cur_next   = r_req_dir;
          w_state_next = S_STEP;
        end else begin
          w_state_next = S_PROBE_CUR;
        end
      end
      S_PROBE_CUR: begin
        w_probe_dir = r_cur_dir;
        if (r_cur_dir != D_NONE && !bus.stop_motion) begin
          w_state_next = S_STEP;
        end else begin
          w_moving_next = 1'b0;
          w_done_next   = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      S_STEP: begin
        case (r_cur_dir)
          D_UP:    w_pos_y_next = r_pos_y - 10'd1;
          D_DOWN:  w_pos_y_next = r_pos_y + 10'd1;
          D_LEFT:  w_pos_x_next = r_pos_x - 10'd1;
          D_RIGHT: w_pos_x_next = r_pos_x + 10'd1;
          default: ;
        endcase
        w_moving_next = 1'b1;
        w_step_next   = r_step_cnt + 4'd1;
        if (r_step_cnt + 4'd1 == STEPS_V) begin
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_PROBE_REQ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_req_dir     <= D_NONE;
      r_cur_dir     <= D_NONE;
      r_pos_x       <= START_X_V;
      r_pos_y       <= START_Y_V;
      r_moving      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_step_cnt    <= 4'd0;
      r_frame_clk_d <= 1'b0;
    end else begin
      r_frame_clk_d <= bus.frame_clk;
      if (w_key_dir != D_NONE) r_req_dir <= w_key_dir;
      r_state       <= w_state_next;
      r_cur_dir     <= w_cur_next;
      r_pos_x       <= w_pos_x_next;
      r_pos_y       <= w_pos_y_next;
      r_moving      <= w_moving_next;
      r_frame_done  <= w_done_next;
      r_step_cnt    <= w_step_next;
    end
  end

  assign w_motion           = dir_to_motion(w_probe_dir);
  assign bus.probe_x_motion = w_motion[19:10];
  assign bus.probe_y_motion = w_motion[9:0];
  assign bus.pos_x          = r_pos_x;
  assign bus.pos_y          = r_pos_y;
  assign bus.cur_dir        = r_cur_dir;
  assign bus.moving         = r_moving;
  assign bus.frame_done     = r_frame_done;
  assign o_state            = r_state;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion: a stubbed collision checker with selectable
// blocked directions, and a second instance configured for three steps per frame.
module tb_pacman_motion;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pacman_motion_if m1 ();
  pacman_motion_if m2 ();
  logic [1:0] st1;
  logic [1:0] st2;

  pacman_motion #(.START_X(16), .START_Y(16), .STEPS_PER_FRAME(1)) u_dut1 (
    .Clk(clk), .Reset(rst), .bus(m1.slave), .o_state(st1)
  );
  pacman_motion #(.START_X(16), .START_Y(100), .STEPS_PER_FRAME(3)) u_dut2 (
    .Clk(clk), .Reset(rst), .bus(m2.slave), .o_state(st2)
  );

  // Collision checker stub: blocks any probe in a selected direction.
  logic blk_all = 1'b0;
  logic blk_down = 1'b0;
  assign m1.stop_motion = blk_all | (blk_down && m1.probe_y_motion == 10'h001);
  assign m2.stop_motion = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;
  int d0;

  always @(negedge clk) begin
    if (m1.frame_done === 1'b1) done_cnt1++;
    if (m2.frame_done === 1'b1) done_cnt2++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise frame_clk for one cycle; returns in cycle E+cycles.
  task automatic run_frame1(input int cycles);
    m1.frame_clk = 1'b1;
    tick();
    m1.frame_clk = 1'b0;
    repeat (cycles - 1) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (m1.pos_x !== 10'd16) begin $display("FAIL reset_pos_x got %0d expected 16", m1.pos_x); n_err++; end
    n_vec++; if (m1.pos_y !== 10'd16) begin $display("FAIL reset_pos_y got %0d expected 16", m1.pos_y); n_err++; end
    n_vec++; if (m1.cur_dir !== 3'd0) begin $display("FAIL reset_cur_dir got %0d expected 0", m1.cur_dir); n_err++; end
    n_vec++; if (m1.probe_x_motion !== 10'h0 || m1.probe_y_motion !== 10'h0) begin
      $display("FAIL reset_probes got %h/%h expected 000/000", m1.probe_x_motion, m1.probe_y_motion); n_err++; end
    n_vec++; if (m1.frame_done !== 1'b0 || m1.moving !== 1'b0) begin
      $display("FAIL reset_flags got done=%b moving=%b expected 0/0", m1.frame_done, m1.moving); n_err++; end
    n_vec++; if (m2.pos_y !== 10'd100) begin $display("FAIL reset_pos_y2 got %0d expected 100", m2.pos_y); n_err++; end
    repeat (5) tick();
    n_vec++; if (m1.pos_x !== 10'd16 || m1.pos_y !== 10'd16 || st1 !== 2'd0) begin
      $display("FAIL reset_idle_hold got (%0d,%0d) st=%0d expected (16,16) st=0", m1.pos_x, m1.pos_y, st1); n_err++; end
  endtask

  task automatic test_free_right();
    m1.keycode = 8'h07;
    tick();
    m1.keycode = 8'h00;
    d0 = done_cnt1;
    m1.frame_clk = 1'b1;
    tick();
    m1.frame_clk = 1'b0;
    n_vec++; if (st1 !== 2'd1 || m1.probe_x_motion !== 10'h001 || m1.probe_y_motion !== 10'h000) begin
      $display("FAIL right_probe_req got st=%0d x=%h y=%h expected st=1 x=001 y=000", st1, m1.probe_x_motion, m1.probe_y_motion); n_err++; end
    tick();
    n_vec++; if (st1 !== 2'd3 || m1.probe_x_motion !== 10'h000) begin
      $display("FAIL right_step got st=%0d x=%h expected st=3 x=000", st1, m1.probe_x_motion); n_err++; end
    tick();
    n_vec++; if (m1.pos_x !== 10'd17 || m1.cur_dir !== 3'd4 || m1.moving !== 1'b1 || m1.frame_done !== 1'b1) begin
      $display("FAIL right_result got x=%0d dir=%0d mv=%b done=%b expected x=17 dir=4 mv=1 done=1",
               m1.pos_x, m1.cur_dir, m1.moving, m1.frame_done); n_err++; end
    repeat (3) tick();
    n_vec++; if (done_cnt1 - d0 !== 1) begin $display("FAIL right_done_count got %0d expected 1", done_cnt1 - d0); n_err++; end
  endtask

  task automatic test_buffered_turn();
    m1.keycode = 8'h16;
    blk_down = 1'b1;
    tick();
    m1.keycode = 8'h00;
    m1.frame_clk = 1'b1;
    tick();
    m1.frame_clk = 1'b0;
    n_vec++; if (m1.probe_y_motion !== 10'h001) begin $display("FAIL turn_probe_req got y=%h expected 001", m1.probe_y_motion); n_err++; end
    tick();
    n_vec++; if (st1 !== 2'd2 || m1.probe_x_motion !== 10'h001) begin
      $display("FAIL turn_probe_cur got st=%0d x=%h expected st=2 x=001", st1, m1.probe_x_motion); n_err++; end
    tick();
    tick();
    n_vec++; if (m1.pos_x !== 10'd18 || m1.pos_y !== 10'd16 || m1.cur_dir !== 3'd4 || m1.frame_done !== 1'b1) begin
      $display("FAIL turn_frame1 got (%0d,%0d) dir=%0d done=%b expected (18,16) dir=4 done=1",
               m1.pos_x, m1.pos_y, m1.cur_dir, m1.frame_done); n_err++; end
    tick();
    blk_down = 1'b0;
    run_frame1(3);
    n_vec++; if (m1.pos_x !== 10'd18 || m1.pos_y !== 10'd17 || m1.cur_dir !== 3'd2) begin
      $display("FAIL turn_frame2 got (%0d,%0d) dir=%0d expected (18,17) dir=2", m1.pos_x, m1.pos_y, m1.cur_dir); n_err++; end
    tick();
  endtask

  task automatic test_blocked_stop();
    m1.keycode = 8'h04;
    tick();
    m1.keycode = 8'h00;
    run_frame1(3);
    n_vec++; if (m1.pos_x !== 10'd17 || m1.cur_dir !== 3'd3) begin
      $display("FAIL blocked_setup got x=%0d dir=%0d expected x=17 dir=3", m1.pos_x, m1.cur_dir); n_err++; end
    tick();
    blk_all = 1'b1;
    m1.frame_clk = 1'b1;
    tick();
    m1.frame_clk = 1'b0;
    tick();
    n_vec++; if (st1 !== 2'd2 || m1.probe_x_motion !== 10'h3FF || m1.frame_done !== 1'b0) begin
      $display("FAIL blocked_e2 got st=%0d x=%h done=%b expected st=2 x=3ff done=0", st1, m1.probe_x_motion, m1.frame_done); n_err++; end
    tick();
    n_vec++; if (m1.frame_done !== 1'b1 || m1.moving !== 1'b0 || m1.cur_dir !== 3'd3 ||
                 m1.pos_x !== 10'd17 || m1.pos_y !== 10'd17) begin
      $display("FAIL blocked_e3 got done=%b mv=%b dir=%0d (%0d,%0d) expected done=1 mv=0 dir=3 (17,17)",
               m1.frame_done, m1.moving, m1.cur_dir, m1.pos_x, m1.pos_y); n_err++; end
    tick();
    blk_all = 1'b0;
  endtask

  task automatic test_multi_step();
    m2.keycode = 8'h1A;
    tick();
    m2.keycode = 8'h00;
    m2.frame_clk = 1'b1;
    tick();
    m2.frame_clk = 1'b0;
    tick();
    m2.frame_clk = 1'b1;
    tick();
    n_vec++; if (st2 !== 2'd1 || m2.pos_y !== 10'd99) begin
      $display("FAIL multi_mid got st=%0d y=%0d expected st=1 y=99", st2, m2.pos_y); n_err++; end
    m2.frame_clk = 1'b0;
    d0 = done_cnt2;
    repeat (4) tick();
    n_vec++; if (m2.pos_y !== 10'd97 || m2.pos_x !== 10'd16 || m2.frame_done !== 1'b1) begin
      $display("FAIL multi_end got (%0d,%0d) done=%b expected (16,97) done=1", m2.pos_x, m2.pos_y, m2.frame_done); n_err++; end
    repeat (4) tick();
    n_vec++; if (done_cnt2 - d0 !== 1 || m2.pos_y !== 10'd97) begin
      $display("FAIL multi_once got pulses=%0d y=%0d expected 1 97", done_cnt2 - d0, m2.pos_y); n_err++; end
  endtask

  task automatic test_extra_edge_reset();
    d0 = done_cnt1;
    m1.frame_clk = 1'b1;
    tick();
    m1.frame_clk = 1'b0;
    tick();
    m1.frame_clk = 1'b1;
    tick();
    m1.frame_clk = 1'b0;
    n_vec++; if (m1.pos_x !== 10'd16 || m1.frame_done !== 1'b1) begin
      $display("FAIL extra_step got x=%0d done=%b expected x=16 done=1", m1.pos_x, m1.frame_done); n_err++; end
    repeat (4) tick();
    n_vec++; if (m1.pos_x !== 10'd16 || done_cnt1 - d0 !== 1 || st1 !== 2'd0) begin
      $display("FAIL extra_ignored got x=%0d pulses=%0d st=%0d expected 16 1 0", m1.pos_x, done_cnt1 - d0, st1); n_err++; end
    m1.keycode = 8'h1A;
    tick();
    m1.keycode = 8'h00;
    m1.frame_clk = 1'b1;
    tick();
    m1.frame_clk = 1'b0;
    tick();
    n_vec++; if (st1 !== 2'd3) begin $display("FAIL rst_in_step got st=%0d expected 3", st1); n_err++; end
    d0 = done_cnt1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (m1.pos_x !== 10'd16 || m1.pos_y !== 10'd16 || m1.cur_dir !== 3'd0 ||
                 m1.frame_done !== 1'b0 || st1 !== 2'd0) begin
      $display("FAIL rst_abort got (%0d,%0d) dir=%0d done=%b st=%0d expected (16,16) 0 0 0",
               m1.pos_x, m1.pos_y, m1.cur_dir, m1.frame_done, st1); n_err++; end
    repeat (3) tick();
    n_vec++; if (done_cnt1 - d0 !== 0 || m1.pos_y !== 10'd16) begin
      $display("FAIL rst_no_done got pulses=%0d y=%0d expected 0 16", done_cnt1 - d0, m1.pos_y); n_err++; end
  endtask

  initial begin
    m1.frame_clk = 1'b0;
    m1.keycode   = 8'h00;
    m2.frame_clk = 1'b0;
    m2.keycode   = 8'h00;
    test_reset();
    test_free_right();
    test_buffered_turn();
    test_blocked_stop();
    test_multi_step();
    test_extra_edge_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pacman_motion.md
# pacman_motion

Per-frame motion controller for the Pac-Man sprite. It latches the player's requested direction from the keyboard keycode. On each frame tick it probes the wall-collision checker, first with the requested direction and then with the current heading, and advances the sprite position one pixel per permitted step. It sits directly upstream of the collision checker: it drives the checker's position and motion inputs and consumes its stop_motion result, and its position outputs feed the sprite renderer.

## Interface
- START_X, default 16: X position loaded on reset (top-left pixel of the 8x8 sprite).
- START_Y, default 16: Y position loaded on reset.
- STEPS_PER_FRAME, default 1: number of 1-pixel steps attempted per frame tick, range 1..15.
- Clk  in  1: system clock. All state updates on the rising edge.
- Reset  in  1: synchronous, active-high.
- frame_clk  in  1: frame tick (vsync-derived). Synchronous to Clk.
- keycode  in  8: USB HID keycode. 0x1A=W (up), 0x04=A (left), 0x16=S (down), 0x07=D (right).
- stop_motion  in  1: combinational result from the collision checker for the current pos/probe inputs.
- pos_x  out  10: sprite X. Also drives the checker's X input.
- pos_y  out  10: sprite Y. Also drives the checker's Y input.
- probe_x_motion  out  10: X motion driven to the checker. Values: 10'h001 = right, 10'h3FF = left, 0 = none.
- probe_y_motion  out  10: Y motion driven to the checker. Values: 10'h001 = down, 10'h3FF = up, 0 = none.
- cur_dir  out  3: current heading. 0=NONE, 1=UP, 2=DOWN, 3=LEFT, 4=RIGHT.
- moving  out  1: 1 if the last step opportunity moved the sprite.
- frame_done  out  1: one-cycle pulse when the frame's step sequence completes.

## Operation
- **Request latch (req_dir).** Every cycle, a keycode matching W/A/S/D loads req_dir. Any other keycode, including 0, leaves req_dir unchanged, so a turn request stays buffered until it becomes possible.
- **Frame edge detection.** frame_clk_d is a register copy of frame_clk. frame_edge = frame_clk & ~frame_clk_d.
- **States:** IDLE, PROBE_REQ, PROBE_CUR, STEP.
- **IDLE**
  - Probe motions are 0.
  - On frame_edge, clear step_cnt and go to PROBE_REQ.
- **PROBE_REQ**
  - Drive the req_dir encoding on the probe outputs.
  - If req_dir != NONE and stop_motion=0: cur_dir <= req_dir, go to STEP.
  - Otherwise go to PROBE_CUR.
- **PROBE_CUR**
  - Drive the cur_dir encoding on the probe outputs.
  - If cur_dir != NONE and stop_motion=0: go to STEP.
  - Otherwise: moving <= 0, pulse frame_done, go to IDLE. No further steps this frame.
  - cur_dir is kept when blocked.
- **STEP**
  - Probe motions are 0.
  - Position update by cur_dir: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1. Arithmetic is modulo 1024.
  - moving <= 1 and step_cnt <= step_cnt+1.
  - If step_cnt+1 == STEPS_PER_FRAME: pulse frame_done, go to IDLE. Otherwise go to PROBE_REQ.
- **Direction encoding:** UP y=3FF, DOWN y=001, LEFT x=3FF, RIGHT x=001, NONE both 0. The unused axis is always 0.
- **Wall containment.** The collision checker is the only wall authority; this block never moves without a clear probe in the same pass. Out-of-range positions can only occur if the checker permits them.

## Timing
- **Reset values (next edge with Reset=1):**
  - pos_x=START_X, pos_y=START_Y.
  - cur_dir=NONE, req_dir=NONE.
  - moving=0, frame_done=0.
  - probe motions 0, state IDLE, step_cnt=0, frame_clk_d=0.
- **Reset mid-sequence:** abort the sequence and apply the reset values. No frame_done pulse.
- **Latency from the frame_edge cycle E:**
  - PROBE_REQ in E+1.
  - STEP in E+2 (request clear) or E+3 (via PROBE_CUR).
  - The updated position is visible in the cycle after STEP.
  - frame_done is asserted in the cycle after the final STEP or the blocking PROBE_CUR.
- **stop_motion sampling:** stop_motion is sampled in the same cycle the probe is driven. pos_x/pos_y are stable through every PROBE state.
- **frame_edge while not IDLE:** ignored, not queued.
- **Keycode changes:** a keycode change in the same cycle as PROBE_REQ takes effect at the next PROBE_REQ. PROBE_REQ uses the registered req_dir.
- **Worst case:** 1 + 3*STEPS_PER_FRAME cycles per frame, far below one frame period.

## Test plan
- **Reset behaviour:** Reset high for 2 cycles, then release. pos=(16,16), cur_dir=0, probe motions 0, frame_done=0. With no frame_clk toggles, nothing changes.
- **Free right move:** keycode=0x07, stub stop_motion=0, one frame_clk rise.
  - PROBE_REQ drives x_motion=001 at E+1.
  - Then pos_x=17, cur_dir=4, moving=1, and a single frame_done pulse.
- **Buffered turn:**
  - Setup: heading RIGHT, keycode=0x16.
  - Frame 1: stop_motion=1 when probe_y=001 and 0 when probe_x=001. Result: x+1, cur_dir stays 4.
  - Frame 2: release the y block. Result: y+1, cur_dir=2.
- **Blocked stop:** cur_dir=LEFT, req=LEFT, stop_motion=1 for all probes. After the frame: position unchanged, moving=0, cur_dir=3, frame_done at E+3.
- **Multi-step:** STEPS_PER_FRAME=3, keycode=0x1A, clear path from y=100. After the frame: pos_y=97, frame_done exactly once.
- **Extra edge, then reset:**
  - frame_clk rises again during PROBE_REQ: ignored, only one step taken.
  - Then assert Reset during STEP: pos returns to (16,16) with no frame_done pulse.
